// File: rtl/fp_stream_accumulator.sv
// Multi-channel floating-point stream accumulator.
// Samples arrive round-robin over N_CH channels on an AXI-Stream slave; each is
// added into its channel accumulator through a five-cycle align/add/normalise/round
// sequence. At frame end (tlast) every channel sum is streamed out, ch0 first.
module fp_stream_accumulator #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int N_CH  = 2,
   localparam int DATA_WIDTH = 1 + EXP_W + MAN_W
) (
   input  logic                    s00_axi_aclk,
   input  logic                    s00_axi_areset,
   output logic                    s00_axis_tready,
   input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
   input  logic                    s00_axis_tlast,
   input  logic                    s00_axis_tvalid,
   output logic                    m00_axis_tvalid,
   output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
   output logic                    m00_axis_tlast,
   input  logic                    m00_axis_tready,
   output logic                    frame_err,
   output logic                    busy
);

   localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int ACC_N = 1 << CH_W;
   // significand with hidden bit plus guard, round and sticky
   localparam int SW    = MAN_W + 4;
   // signed exponent wide enough for carry and a full left normalisation
   localparam int EW    = ((EXP_W > $clog2(SW + 1)) ? EXP_W : $clog2(SW + 1)) + 2;
   localparam logic [CH_W-1:0]       LAST_CH = CH_W'(N_CH - 1);
   localparam logic signed [EW-1:0]  EXP_MAX = EW'((1 << EXP_W) - 1);
   localparam logic [DATA_WIDTH-1:0] QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, OUT} state_t;

   state_t                  state;
   logic [DATA_WIDTH-1:0]   acc [ACC_N];
   logic [CH_W-1:0]         ch;
   logic [CH_W-1:0]         out_idx;
   logic [CH_W-1:0]         next_idx;

   // pipeline registers carried between FSM states
   logic [DATA_WIDTH-1:0]   op_a, op_b;
   logic                    last_r;
   logic                    spec_r;
   logic [DATA_WIDTH-1:0]   spec_val_r;
   logic                    sign_r;
   logic                    sub_r;
   logic signed [EW-1:0]    exp_r;
   logic [SW-1:0]           big_sig_r, small_sig_r;
   logic [SW:0]             sum_r;
   logic [SW-1:0]           norm_r;
   logic                    zero_r;

   // align-stage combinational signals
   logic                    a_sign, b_sign;
   logic [EXP_W-1:0]        a_exp, b_exp;
   logic [MAN_W-1:0]        a_man, b_man;
   logic                    a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic                    sp;
   logic [DATA_WIDTH-1:0]   sp_val;
   logic                    a_big;
   logic                    big_s;
   logic [EXP_W-1:0]        big_e, small_e, diff;
   logic [MAN_W-1:0]        big_m, small_m;
   logic [SW-1:0]           small_full, small_al;

   // add / normalise / round combinational signals
   logic [SW:0]             sum_c;
   logic [EW-1:0]           lzc;
   logic                    found;
   logic [SW-1:0]           nsig;
   logic signed [EW-1:0]    nexp;
   logic                    round_up;
   logic [MAN_W+1:0]        mant_c;
   logic [MAN_W-1:0]        rman;
   logic signed [EW-1:0]    rexp;
   logic [DATA_WIDTH-1:0]   result;

   assign s00_axis_tready = (state == IDLE);
   assign busy            = (state != IDLE);
   assign m00_axis_tstrb  = '1;
   assign next_idx        = out_idx + CH_W'(1);

   // Classify operands, resolve special cases and align the smaller significand.
   always_comb begin
      a_sign = op_a[DATA_WIDTH-1];
      b_sign = op_b[DATA_WIDTH-1];
      a_exp  = op_a[DATA_WIDTH-2:MAN_W];
      b_exp  = op_b[DATA_WIDTH-2:MAN_W];
      a_man  = op_a[MAN_W-1:0];
      b_man  = op_b[MAN_W-1:0];
      a_zero = (a_exp == '0);
      b_zero = (b_exp == '0);
      a_inf  = (a_exp == '1) && (a_man == '0);
      b_inf  = (b_exp == '1) && (b_man == '0);
      a_nan  = (a_exp == '1) && (a_man != '0);
      b_nan  = (b_exp == '1) && (b_man != '0);

      sp     = 1'b1;
      sp_val = QNAN;
      if (a_nan || b_nan)        sp_val = QNAN;
      else if (a_inf && b_inf)   sp_val = (a_sign == b_sign) ? op_a : QNAN;
      else if (a_inf)            sp_val = op_a;
      else if (b_inf)            sp_val = op_b;
      else if (a_zero && b_zero) sp_val = {a_sign & b_sign, {(DATA_WIDTH-1){1'b0}}};
      else if (a_zero)           sp_val = op_b;
      else if (b_zero)           sp_val = op_a;
      else                       sp = 1'b0;

      // comparing exponent:mantissa as one field orders magnitudes, so the
      // subtract path never goes negative
      a_big   = (op_a[DATA_WIDTH-2:0] >= op_b[DATA_WIDTH-2:0]);
      big_s   = a_big ? a_sign : b_sign;
      big_e   = a_big ? a_exp  : b_exp;
      small_e = a_big ? b_exp  : a_exp;
      big_m   = a_big ? a_man  : b_man;
      small_m = a_big ? b_man  : a_man;
      diff    = big_e - small_e;

      small_full = {1'b1, small_m, 3'b000};
      if (32'(diff) >= MAN_W + 3) begin
         small_al = SW'(1);
      end else begin
         small_al    = small_full >> diff;
         small_al[0] = small_al[0] | (|(small_full & ~({SW{1'b1}} << diff)));
      end
   end

   // Magnitude add or subtract of the aligned significands.
   always_comb begin
      if (sub_r) sum_c = {1'b0, big_sig_r} - {1'b0, small_sig_r};
      else       sum_c = {1'b0, big_sig_r} + {1'b0, small_sig_r};
   end

   // Normalise: one-bit right shift on carry, otherwise leading-zero shift left.
   always_comb begin
      lzc   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < SW; i++) begin
         if (!found) begin
            if (sum_r[SW-1-i]) found = 1'b1;
            else               lzc   = lzc + EW'(1);
         end
      end
      if (sum_r[SW]) begin
         nsig = {sum_r[SW:2], sum_r[1] | sum_r[0]};
         nexp = exp_r + EW'(1);
      end else begin
         nsig = sum_r[SW-1:0] << lzc;
         nexp = exp_r - lzc;
      end
   end

   // Round to nearest even, then apply overflow/underflow and special results.
   always_comb begin
      round_up = norm_r[2] & (norm_r[1] | norm_r[0] | norm_r[3]);
      mant_c   = {1'b0, norm_r[SW-1:3]} + {{(MAN_W+1){1'b0}}, round_up};
      if (mant_c[MAN_W+1]) begin
         rman = '0;
         rexp = exp_r + EW'(1);
      end else begin
         rman = mant_c[MAN_W-1:0];
         rexp = exp_r;
      end
      if (spec_r)                          result = spec_val_r;
      else if (zero_r)                     result = '0;
      else if (rexp >= EXP_MAX)            result = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if (rexp[EW-1] || rexp == '0)   result = {sign_r, {(DATA_WIDTH-1){1'b0}}};
      else                                 result = {sign_r, rexp[EXP_W-1:0], rman};
   end

   // Control FSM with accumulator bank and registered stream outputs.
   always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
      if (s00_axi_areset) begin
         state           <= IDLE;
         for (int unsigned i = 0; i < ACC_N; i++) acc[i] <= '0;
         ch              <= '0;
         out_idx         <= '0;
         m00_axis_tvalid <= 1'b0;
         m00_axis_tdata  <= '0;
         m00_axis_tlast  <= 1'b0;
         frame_err       <= 1'b0;
         op_a            <= '0;
         op_b            <= '0;
         last_r          <= 1'b0;
         spec_r          <= 1'b0;
         spec_val_r      <= '0;
         sign_r          <= 1'b0;
         sub_r           <= 1'b0;
         exp_r           <= '0;
         big_sig_r       <= '0;
         small_sig_r     <= '0;
         sum_r           <= '0;
         norm_r          <= '0;
         zero_r          <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               if (s00_axis_tvalid) begin
                  op_a   <= acc[ch];
                  op_b   <= s00_axis_tdata;
                  last_r <= s00_axis_tlast;
                  state  <= ALIGN;
               end
            end
            ALIGN: begin
               spec_r      <= sp;
               spec_val_r  <= sp_val;
               sign_r      <= big_s;
               sub_r       <= a_sign ^ b_sign;
               exp_r       <= EW'(big_e);
               big_sig_r   <= {1'b1, big_m, 3'b000};
               small_sig_r <= small_al;
               state       <= ADD;
            end
            ADD: begin
               sum_r <= sum_c;
               state <= NORM;
            end
            NORM: begin
               norm_r    <= nsig;
               exp_r     <= nexp;
               zero_r    <= (sum_r == '0);
               // registered so the pulse coincides with the ROUND cycle
               frame_err <= last_r && (ch != LAST_CH);
               state     <= ROUND;
            end
            ROUND: begin
               acc[ch] <= result;
               if (last_r) begin
                  ch              <= '0;
                  out_idx         <= '0;
                  m00_axis_tvalid <= 1'b1;
                  // acc[0] is being written this same edge when ch is 0
                  m00_axis_tdata  <= (ch == '0) ? result : acc[0];
                  m00_axis_tlast  <= (LAST_CH == '0);
                  state           <= OUT;
               end else begin
                  ch    <= (ch == LAST_CH) ? '0 : ch + CH_W'(1);
                  state <= IDLE;
               end
            end
            OUT: begin
               if (m00_axis_tready) begin
                  acc[out_idx] <= '0;
                  if (out_idx == LAST_CH) begin
                     m00_axis_tvalid <= 1'b0;
                     m00_axis_tlast  <= 1'b0;
                     state           <= IDLE;
                  end else begin
                     out_idx        <= next_idx;
                     m00_axis_tdata <= acc[next_idx];
                     m00_axis_tlast <= (next_idx == LAST_CH);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_stream_accumulator.sv
// Self-checking bench for fp_stream_accumulator: one single-channel and one
// two-channel instance, compared against a real-arithmetic reference model.
module tb_fp_stream_accumulator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        m_ready;
   bit          hold_low;

   logic        s_ready1, s_last1, s_valid1, m_valid1, m_last1, ferr1, busy1;
   logic [31:0] s_data1, m_data1;
   logic [3:0]  m_strb1;
   logic        s_ready2, s_last2, s_valid2, m_valid2, m_last2, ferr2, busy2;
   logic [31:0] s_data2, m_data2;
   logic [3:0]  m_strb2;

   int          checks = 0;
   int          errors = 0;

   logic [32:0] q1[$];
   logic [32:0] q2[$];
   logic [31:0] macc1;
   logic [31:0] macc2[2];
   int unsigned mch2;
   logic [31:0] last_gen = 32'h3F800000;

   fp_stream_accumulator #(.EXP_W(8), .MAN_W(23), .N_CH(1)) dut1 (
      .s00_axi_aclk(clk), .s00_axi_areset(rst),
      .s00_axis_tready(s_ready1), .s00_axis_tdata(s_data1),
      .s00_axis_tlast(s_last1), .s00_axis_tvalid(s_valid1),
      .m00_axis_tvalid(m_valid1), .m00_axis_tdata(m_data1),
      .m00_axis_tstrb(m_strb1), .m00_axis_tlast(m_last1),
      .m00_axis_tready(m_ready), .frame_err(ferr1), .busy(busy1));

   fp_stream_accumulator #(.EXP_W(8), .MAN_W(23), .N_CH(2)) dut2 (
      .s00_axi_aclk(clk), .s00_axi_areset(rst),
      .s00_axis_tready(s_ready2), .s00_axis_tdata(s_data2),
      .s00_axis_tlast(s_last2), .s00_axis_tvalid(s_valid2),
      .m00_axis_tvalid(m_valid2), .m00_axis_tdata(m_data2),
      .m00_axis_tstrb(m_strb2), .m00_axis_tlast(m_last2),
      .m00_axis_tready(m_ready), .frame_err(ferr2), .busy(busy2));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
      end
   endtask

   task automatic fail(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: got event, expected none", nm);
   endtask

   // ---------------- reference model ----------------
   function automatic real to_real(input logic [31:0] x);
      real m;
      int  e;
      m = 1.0 + real'(x[22:0]) / 8388608.0;
      e = int'(x[30:23]) - 127;
      for (int i = 0; i < e; i++) m = m * 2.0;
      for (int i = 0; i > e; i--) m = m * 0.5;
      return x[31] ? -m : m;
   endfunction

   // round a (double-precision exact) sum to single with ties-to-even,
   // no subnormal results
   function automatic logic [31:0] from_real(input real v);
      logic [63:0] b;
      logic [23:0] keep;
      logic [28:0] rest;
      int          fe;
      b    = $realtobits(v);
      keep = {1'b0, b[51:29]};
      rest = b[28:0];
      fe   = int'(b[62:52]) - 1023 + 127;
      if (rest > 29'h1000_0000 || (rest == 29'h1000_0000 && keep[0])) keep = keep + 24'd1;
      if (keep[23]) begin
         keep = '0;
         fe   = fe + 1;
      end
      if (fe >= 255) return {b[63], 8'hFF, 23'h0};
      if (fe <= 0)   return {b[63], 31'h0};
      return {b[63], 8'(fe), keep[22:0]};
   endfunction

   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
      bit  az, bz, ai, bi, an, bn;
      real s;
      az = (a[30:23] == 8'h00);
      bz = (b[30:23] == 8'h00);
      ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
      bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
      an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
      bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
      if (an || bn) return 32'h7FC00000;
      if (ai && bi) return (a[31] == b[31]) ? a : 32'h7FC00000;
      if (ai) return a;
      if (bi) return b;
      if (az && bz) return {a[31] & b[31], 31'h0};
      if (az) return b;
      if (bz) return a;
      s = to_real(a) + to_real(b);
      if (s == 0.0) return 32'h0;
      return from_real(s);
   endfunction

   task automatic model_step(input int unsigned which, input logic [31:0] d,
                             input bit last, output bit fe);
      fe = 1'b0;
      if (which == 1) begin
         macc1 = fadd(macc1, d);
         if (last) begin
            q1.push_back({1'b1, macc1});
            macc1 = '0;
         end
      end else begin
         macc2[mch2] = fadd(macc2[mch2], d);
         if (last) begin
            fe = (mch2 != 1);
            q2.push_back({1'b0, macc2[0]});
            q2.push_back({1'b1, macc2[1]});
            macc2[0] = '0;
            macc2[1] = '0;
            mch2     = 0;
         end else begin
            mch2 = (mch2 + 1) % 2;
         end
      end
   endtask

   task automatic model_clear();
      macc1    = '0;
      macc2[0] = '0;
      macc2[1] = '0;
      mch2     = 0;
   endtask

   // ---------------- stimulus helpers ----------------
   function automatic logic [31:0] gen();
      logic [31:0] r;
      case ($urandom_range(0, 19))
         0:       r = 32'h00000000;
         1:       r = 32'h80000000;
         2:       r = 32'h7F800000;
         3:       r = 32'hFF800000;
         4:       r = 32'h7FA00001;
         5:       r = {1'($urandom_range(0, 1)), 8'h00, 23'($urandom)};
         6:       r = {1'($urandom_range(0, 1)), 8'hFE, 23'($urandom)};
         7:       r = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 3)), 23'($urandom)};
         8, 9:    r = {~last_gen[31], last_gen[30:0]};
         default: r = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
      endcase
      last_gen = r;
      return r;
   endfunction

   task automatic send(input int unsigned which, input logic [31:0] d, input bit last);
      bit          exp_fe;
      int unsigned w;
      int unsigned fe_cnt;
      model_step(which, d, last, exp_fe);
      @(negedge clk);
      if (which == 1) begin s_data1 = d; s_last1 = last; s_valid1 = 1'b1; end
      else            begin s_data2 = d; s_last2 = last; s_valid2 = 1'b1; end
      w = 0;
      while (!((which == 1) ? s_ready1 : s_ready2) && w < 300) begin
         @(negedge clk);
         w++;
      end
      if (w >= 300) begin
         fail("in_ready_timeout");
         s_valid1 = 1'b0;
         s_valid2 = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      s_valid1 = 1'b0;
      s_valid2 = 1'b0;
      fe_cnt = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         fe_cnt += (which == 1) ? 32'(ferr1) : 32'(ferr2);
         chk("in_ready_busy_low", (which == 1) ? s_ready1 : s_ready2, 0);
      end
      chk("frame_err_pulses", fe_cnt, 32'(exp_fe));
   endtask

   task automatic drain();
      int unsigned w;
      w = 0;
      while ((q1.size() != 0 || q2.size() != 0 || busy1 || busy2) && w < 1000) begin
         @(negedge clk);
         w++;
      end
      if (w >= 1000) fail("drain_timeout");
   endtask

   task automatic check_reset_state();
      chk("rst_tready1", s_ready1, 1);
      chk("rst_tready2", s_ready2, 1);
      chk("rst_busy1", busy1, 0);
      chk("rst_busy2", busy2, 0);
      chk("rst_tvalid1", m_valid1, 0);
      chk("rst_tvalid2", m_valid2, 0);
      chk("rst_tdata2", m_data2, 0);
      chk("rst_tlast2", m_last2, 0);
      chk("rst_ferr2", ferr2, 0);
   endtask

   // downstream ready: random, or held low for the backpressure test
   initial begin
      m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // output scoreboard and hold-stability check
   logic        pv1 = 1'b0, pr1 = 1'b0, pv2 = 1'b0, pr2 = 1'b0;
   logic [31:0] pd1 = '0, pd2 = '0;
   logic [32:0] e1, e2;
   always @(negedge clk) begin
      if (!rst) begin
         if (m_valid1) begin
            chk("out1_in_ready_low", s_ready1, 0);
            if (pv1 && !pr1) chk("out1_hold_data", m_data1, pd1);
            if (m_ready) begin
               if (q1.size() == 0) fail("out1_unexpected_word");
               else begin
                  e1 = q1.pop_front();
                  chk("out1_data", m_data1, e1[31:0]);
                  chk("out1_last", m_last1, e1[32]);
               end
            end
         end
         if (m_valid2) begin
            chk("out2_in_ready_low", s_ready2, 0);
            if (pv2 && !pr2) chk("out2_hold_data", m_data2, pd2);
            if (m_ready) begin
               if (q2.size() == 0) fail("out2_unexpected_word");
               else begin
                  e2 = q2.pop_front();
                  chk("out2_data", m_data2, e2[31:0]);
                  chk("out2_last", m_last2, e2[32]);
               end
            end
         end
         pv1 = m_valid1; pr1 = m_ready; pd1 = m_data1;
         pv2 = m_valid2; pr2 = m_ready; pd2 = m_data2;
      end else begin
         pv1 = 1'b0;
         pv2 = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   logic [31:0] held;

   initial begin
      rst = 1'b1;
      hold_low = 1'b0;
      s_valid1 = 1'b0; s_last1 = 1'b0; s_data1 = '0;
      s_valid2 = 1'b0; s_last2 = 1'b0; s_data2 = '0;
      model_clear();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_reset_state();
      chk("tstrb1", m_strb1, 4'hF);
      chk("tstrb2", m_strb2, 4'hF);

      // hand-computed values pinning the model
      chk("pin_sum6", fadd(fadd(fadd(32'h0, 32'h3F800000), 32'h40000000), 32'h40400000), 32'h40C00000);
      chk("pin_cancel", fadd(32'h41200000, 32'hC1200000), 32'h00000000);
      chk("pin_tie_even", fadd(32'h3F800000, 32'h33800000), 32'h3F800000);
      chk("pin_tie_up", fadd(32'h3F800000, 32'h33800001), 32'h3F800001);
      chk("pin_ovf", fadd(32'h7F7FFFFF, 32'h7F7FFFFF), 32'h7F800000);
      chk("pin_inf_nan", fadd(32'h7F800000, 32'hFF800000), 32'h7FC00000);
      chk("pin_denorm", fadd(32'h00400000, 32'h00000000), 32'h00000000);
      chk("pin_negzero", fadd(32'h80000000, 32'h80000000), 32'h80000000);

      // single-channel sum, two-channel sum with cancellation
      send(1, 32'h3F800000, 0); send(1, 32'h40000000, 0); send(1, 32'h40400000, 1);
      send(2, 32'h3F800000, 0); send(2, 32'h41200000, 0);
      send(2, 32'h40000000, 0); send(2, 32'hC1200000, 1);
      // rounding
      send(1, 32'h3F800000, 0); send(1, 32'h33800000, 1);
      send(1, 32'h3F800000, 0); send(1, 32'h33800001, 1);
      // specials
      send(1, 32'h7F7FFFFF, 0); send(1, 32'h7F7FFFFF, 1);
      send(1, 32'h7F800000, 0); send(1, 32'hFF800000, 1);
      send(1, 32'h00400000, 0); send(1, 32'h00000000, 1);
      send(1, 32'h80000000, 0); send(1, 32'h80000000, 1);
      drain();

      // backpressure
      send(1, 32'h3F800000, 0);
      hold_low = 1'b1;
      send(1, 32'h40000000, 1);
      @(negedge clk);
      held = m_data1;
      chk("bp_word", held, 32'h40400000);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("bp_hold_data", m_data1, held);
         chk("bp_hold_valid", m_valid1, 1);
         chk("bp_in_ready_low", s_ready1, 0);
      end
      hold_low = 1'b0;
      send(1, 32'h3F800000, 1);
      drain();

      // tlast on ch0 in two-channel mode
      send(2, 32'h3F800000, 1);
      drain();

      // reset mid-frame
      send(2, 32'h40A00000, 0);
      send(2, 32'h40000000, 0);
      send(2, 32'h40A00000, 0);
      @(negedge clk);
      rst = 1'b1;
      model_clear();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_reset_state();
      send(2, 32'h3F800000, 0);
      send(2, 32'h3F800000, 1);
      drain();

      // randomized frames
      for (int f = 0; f < 30; f++) begin
         int unsigned which;
         int unsigned len;
         which = (f % 4 == 0) ? 1 : 2;
         len   = $urandom_range(1, 6);
         for (int unsigned i = 0; i < len; i++) send(which, gen(), i == len - 1);
      end
      drain();
      chk("q1_empty", q1.size(), 0);
      chk("q2_empty", q2.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
